measurement_stream_rx: RTL and testbench
========================================

MEASUREMENT_STREAM_RX -- requirements
Module: measurement_stream_rx

Interface
REQ-001 SHALL have parameter GRID_WIDTH_X, default 4: X extent of the PU grid.
REQ-002 SHALL have parameter GRID_WIDTH_Z, default 2: Z extent of the PU grid.
REQ-003 SHALL have parameter GRID_WIDTH_U, default 3: number of measurement rounds.
REQ-004 SHALL have parameter START_DECODING_MSG, default 8'h01: start-of-session byte.
REQ-005 SHALL have parameter MEASUREMENT_DATA_HEADER, default 8'h02: start-of-frame byte.
REQ-006 SHALL derive BYTES_PER_ROUND = ceil(X*Z/8), ALIGNED_PU_PER_ROUND = 8*BYTES_PER_ROUND, FRAME_BYTES = BYTES_PER_ROUND*GRID_WIDTH_U, MEAS_WIDTH = ALIGNED_PU_PER_ROUND*GRID_WIDTH_U.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high.
REQ-009 SHALL have port input_data, input, 8: byte stream from host/input FIFO.
REQ-010 SHALL have port input_valid, input, 1: input_data valid.
REQ-011 SHALL have port input_ready, output, 1: block accepts the byte this cycle.
REQ-012 SHALL have port start_decoding, output, 1: one-cycle pulse per accepted START_DECODING_MSG.
REQ-013 SHALL have port measurements, output, MEAS_WIDTH: assembled frame, padded-round layout.
REQ-014 SHALL have port measurements_valid, output, 1: frame complete and held.
REQ-015 SHALL have port measurements_ready, input, 1: downstream consumes the frame.

Function
REQ-016 SHALL transfer a byte only on a cycle with input_valid && input_ready.
REQ-017 SHALL implement states IDLE, HEADER, PAYLOAD, HOLD.
REQ-018 In IDLE, SHALL drive input_ready=1; START_DECODING_MSG -> pulse start_decoding next cycle and go to HEADER; any other byte is discarded.
REQ-019 In HEADER, SHALL drive input_ready=1; MEASUREMENT_DATA_HEADER -> clear byte counter and go to PAYLOAD; START_DECODING_MSG -> pulse start_decoding again and stay; other bytes are discarded.
REQ-020 In PAYLOAD, SHALL drive input_ready=1 and write byte n to measurements[8n+7:8n], n = 0..FRAME_BYTES-1; payload bytes are never interpreted as headers.
REQ-021 On acceptance of byte FRAME_BYTES-1, SHALL enter HOLD with measurements_valid=1 on the next cycle (one-cycle latency from last byte).
REQ-022 In HOLD, SHALL drive input_ready=0, keep measurements and measurements_valid stable until measurements_ready=1, then return to HEADER with measurements_valid=0 next cycle.
REQ-023 SHALL pass padding bits (within each aligned round) through unchanged from the stream.
REQ-024 SHALL retain the last frame on measurements after leaving HOLD until overwritten byte-by-byte by the next frame.
REQ-025 Byte counter SHALL be wide enough for FRAME_BYTES with no wrap before the last byte.
REQ-026 If input_valid drops mid-PAYLOAD, SHALL wait indefinitely with counter held.

Reset
REQ-027 On reset, SHALL enter IDLE, clear byte counter, measurements=0, measurements_valid=0, start_decoding=0; input_ready=1 on the first cycle after reset deasserts.
REQ-028 Reset asserted in any state (incl. mid-PAYLOAD or HOLD) SHALL abandon the partial/held frame with no measurements_valid pulse.

Configuration
REQ-029 With macro MEAS_RX_ERR_CNT_EN defined, SHALL add output port discard_count, 16 bits, reset 0, incrementing (saturating at 16'hFFFF) on every byte discarded in IDLE or HEADER.
REQ-030 Without MEAS_RX_ERR_CNT_EN, discard_count SHALL not exist and discard behaviour is otherwise identical.

Verification (defaults: 1 byte/round, FRAME_BYTES=3, MEAS_WIDTH=24)
REQ-031 Stream 01,02,A5,3C,F0 with measurements_ready=1 -> one start_decoding pulse; measurements=24'hF03CA5, measurements_valid high exactly one cycle, back in HEADER.
REQ-032 Stream 01,02,11,22,33 with measurements_ready=0 for 10 cycles, then byte 02 offered -> input_ready=0 and measurements=24'h332211 stable throughout; 02 accepted only after measurements_ready=1.
REQ-033 Stream 7F,02,01 from reset -> 7F and 02 discarded in IDLE, start_decoding pulses once on 01; with MEAS_RX_ERR_CNT_EN, discard_count=2.
REQ-034 Stream 01,02,01,02,02 -> payload bytes 01,02,02 not treated as headers; measurements=24'h020201.
REQ-035 Stream 01,02,AA,BB then reset for 1 cycle, then 01,02,01,02,03 -> no valid for the partial frame; single frame 24'h030201.
REQ-036 Random input_valid gaps (50%) over 100 frames -> every frame equals the sent bytes, byte 0 in bits [7:0].

Source files
------------

// File: rtl/measurement_stream_rx.sv
// Byte-stream receiver: waits for a start-of-session byte, then assembles fixed-size
// measurement frames after each frame header. Optional MEAS_RX_ERR_CNT_EN adds discard_count.
module measurement_stream_rx #(
  parameter int          GRID_WIDTH_X            = 4,
  parameter int          GRID_WIDTH_Z            = 2,
  parameter int          GRID_WIDTH_U            = 3,
  parameter logic [7:0]  START_DECODING_MSG      = 8'h01,
  parameter logic [7:0]  MEASUREMENT_DATA_HEADER = 8'h02,
  localparam int BYTES_PER_ROUND      = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) / 8,
  localparam int ALIGNED_PU_PER_ROUND = 8 * BYTES_PER_ROUND,
  localparam int FRAME_BYTES          = BYTES_PER_ROUND * GRID_WIDTH_U,
  localparam int MEAS_WIDTH           = ALIGNED_PU_PER_ROUND * GRID_WIDTH_U
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            input_data,
  input  logic                  input_valid,
  output logic                  input_ready,
  output logic                  start_decoding,
  output logic [MEAS_WIDTH-1:0] measurements,
  output logic                  measurements_valid,
  input  logic                  measurements_ready
`ifdef MEAS_RX_ERR_CNT_EN
  ,
  output logic [15:0]           discard_count
`endif
);

  localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, HOLD} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ready_q;
  logic                  start_q;
  logic                  valid_q;
  logic [MEAS_WIDTH-1:0] meas_q;
  logic                  fire;

  assign fire               = input_valid && ready_q;
  assign input_ready        = ready_q;
  assign start_decoding     = start_q;
  assign measurements       = meas_q;
  assign measurements_valid = valid_q;

  // All outputs are registered; input_ready is low exactly while a frame is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      // NOTE: the frame register is wide but is still cleared, since downstream may read it before the first frame.
      meas_q  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire && input_data == START_DECODING_MSG) begin
            start_q <= 1'b1;
            state_q <= HEADER;
          end
        end
        HEADER: begin
          if (fire) begin
            if (input_data == MEASUREMENT_DATA_HEADER) begin
              cnt_q   <= '0;
              state_q <= PAYLOAD;
            end else if (input_data == START_DECODING_MSG) begin
              start_q <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (fire) begin
            for (int n = 0; n < FRAME_BYTES; n++) begin
              if (cnt_q == CNT_W'(n)) meas_q[8*n +: 8] <= input_data;
            end
            if (cnt_q == LAST_CNT) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (measurements_ready) begin
            state_q <= HEADER;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEAS_RX_ERR_CNT_EN
  logic        discard;
  logic [15:0] discard_q;

  always_comb begin
    discard = 1'b0;
    if (fire) begin
      if (state_q == IDLE)
        discard = (input_data != START_DECODING_MSG);
      else if (state_q == HEADER)
        discard = (input_data != START_DECODING_MSG) && (input_data != MEASUREMENT_DATA_HEADER);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      discard_q <= '0;
    else if (discard && discard_q != 16'hFFFF)
      discard_q <= discard_q + 16'd1;
  end

  assign discard_count = discard_q;
`endif

endmodule

// File: tb/tb_measurement_stream_rx.sv
// Self-checking bench for measurement_stream_rx at default parameters (3-byte frames).
module tb_measurement_stream_rx;

  localparam int MW = 24;
  localparam int FB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    input_data;
  logic          input_valid;
  logic          input_ready;
  logic          start_decoding;
  logic [MW-1:0] measurements;
  logic          measurements_valid;
  logic          measurements_ready;
`ifdef MEAS_RX_ERR_CNT_EN
  logic [15:0]   discard_count;
`endif

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int vrise = 0;
  logic prev_v = 1'b0;

  measurement_stream_rx dut (
    .clk                (clk),
    .reset              (reset),
    .input_data         (input_data),
    .input_valid        (input_valid),
    .input_ready        (input_ready),
    .start_decoding     (start_decoding),
    .measurements       (measurements),
    .measurements_valid (measurements_valid),
    .measurements_ready (measurements_ready)
`ifdef MEAS_RX_ERR_CNT_EN
    ,
    .discard_count      (discard_count)
`endif
  );

  always #5 clk = ~clk;

  // Count start pulses and frame deliveries (rising edges of valid) away from the active edge.
  always @(negedge clk) begin
    if (start_decoding) start_cnt++;
    if (measurements_valid && !prev_v) vrise++;
    prev_v = measurements_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    input_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Offer one byte until it is taken; a byte that is never taken is reported as a failure.
  task automatic send_byte(input logic [7:0] b);
    int   n = 0;
    logic took = 1'b0;
    input_data  = b;
    input_valid = 1'b1;
    while (!took && n < 200) begin
      took = input_ready;
      tick();
      n++;
    end
    input_valid = 1'b0;
    total++;
    if (!took) begin
      bad++;
      $display("FAIL send_byte: byte %h not accepted, ready=%b want 1", b, input_ready);
    end
  endtask

  task automatic send_gapped(input logic [7:0] b);
    while ($urandom_range(1, 0) == 1) tick();
    send_byte(b);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    input_valid = 1'b1;
    input_data = 8'h01;
    measurements_ready = 1'b0;
    tick();
    tick();
    input_valid = 1'b0;
    reset = 1'b0;
    total++; if (input_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", input_ready); end
    total++; if (measurements_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", measurements_valid); end
    total++; if (start_decoding !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", start_decoding); end
    total++; if (measurements !== 24'h0) begin bad++; $display("FAIL reset_meas: got %h want 000000", measurements); end
  endtask

  task automatic test_basic();
    int s0, v0;
    do_reset();
    s0 = start_cnt;
    v0 = vrise;
    measurements_ready = 1'b1;
    send_byte(8'h01);
    total++; if (start_decoding !== 1'b1) begin bad++; $display("FAIL basic_start_pulse: got %b want 1", start_decoding); end
    send_byte(8'h02);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'hF0);
    total++; if (measurements_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", measurements_valid); end
    total++; if (measurements !== 24'hF03CA5) begin bad++; $display("FAIL basic_meas: got %h want f03ca5", measurements); end
    tick();
    total++; if (measurements_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b want 0", measurements_valid); end
    total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL basic_start_count: got %0d want 1", start_cnt - s0); end
    total++; if (vrise - v0 != 1) begin bad++; $display("FAIL basic_frame_count: got %0d want 1", vrise - v0); end
  endtask

  // A frame straight after the previous one, with no new start byte: block must be in HEADER.
  task automatic test_back_to_back();
    measurements_ready = 1'b1;
    send_byte(8'h02);
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h0F);
    total++; if (measurements_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", measurements_valid); end
    total++; if (measurements !== 24'h0FC35A) begin bad++; $display("FAIL b2b_meas: got %h want 0fc35a", measurements); end
    tick();
    total++; if (measurements !== 24'h0FC35A) begin bad++; $display("FAIL b2b_retain: got %h want 0fc35a", measurements); end
  endtask

  task automatic test_hold();
    do_reset();
    measurements_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (input_ready !== 1'b0 || measurements_valid !== 1'b1 || measurements !== 24'h332211) begin
        bad++;
        $display("FAIL hold_stable[%0d]: got ready=%b valid=%b meas=%h want 0 1 332211",
                 i, input_ready, measurements_valid, measurements);
      end
      tick();
    end
    input_data = 8'h02;
    input_valid = 1'b1;
    tick();
    tick();
    total++; if (input_ready !== 1'b0) begin bad++; $display("FAIL hold_blocks: got ready=%b want 0", input_ready); end
    measurements_ready = 1'b1;
    tick();
    measurements_ready = 1'b0;
    total++; if (measurements_valid !== 1'b0 || input_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release: got valid=%b ready=%b want 0 1", measurements_valid, input_ready);
    end
    total++; if (measurements !== 24'h332211) begin bad++; $display("FAIL hold_retain: got %h want 332211", measurements); end
    tick();
    input_valid = 1'b0;
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    total++; if (measurements_valid !== 1'b1 || measurements !== 24'hEFCDAB) begin
      bad++; $display("FAIL hold_next_frame: got valid=%b meas=%h want 1 efcdab", measurements_valid, measurements);
    end
    measurements_ready = 1'b1;
    tick();
  endtask

  task automatic test_discard();
    int s0;
    do_reset();
    s0 = start_cnt;
    measurements_ready = 1'b1;
    send_byte(8'h7F);
    send_byte(8'h02);
    total++; if (start_decoding !== 1'b0) begin bad++; $display("FAIL discard_no_start: got %b want 0", start_decoding); end
    send_byte(8'h01);
    total++; if (start_decoding !== 1'b1) begin bad++; $display("FAIL discard_start: got %b want 1", start_decoding); end
    tick();
    total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL discard_start_count: got %0d want 1", start_cnt - s0); end
`ifdef MEAS_RX_ERR_CNT_EN
    total++; if (discard_count !== 16'd2) begin bad++; $display("FAIL discard_count: got %0d want 2", discard_count); end
`endif
  endtask

  task automatic test_payload_no_hdr();
    int s0;
    do_reset();
    s0 = start_cnt;
    measurements_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h02);
    total++; if (measurements_valid !== 1'b1 || measurements !== 24'h020201) begin
      bad++; $display("FAIL payload_raw: got valid=%b meas=%h want 1 020201", measurements_valid, measurements);
    end
    tick();
    total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL payload_start_count: got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    int v0;
    do_reset();
    v0 = vrise;
    measurements_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    total++; if (measurements_valid !== 1'b0 || measurements !== 24'h0) begin
      bad++; $display("FAIL midreset_clear: got valid=%b meas=%h want 0 000000", measurements_valid, measurements);
    end
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    total++; if (measurements !== 24'h030201) begin bad++; $display("FAIL midreset_meas: got %h want 030201", measurements); end
    tick();
    total++; if (vrise - v0 != 1) begin bad++; $display("FAIL midreset_frames: got %0d want 1", vrise - v0); end
  endtask

  // Random frames with input gaps, junk between frames and random consumer delay.
  task automatic test_random();
    int v0;
    logic [7:0] q[$];
    logic [MW-1:0] exp;
    do_reset();
    v0 = vrise;
    measurements_ready = 1'b0;
    send_gapped(8'h01);
    for (int f = 0; f < 100; f++) begin
      if ($urandom_range(3, 0) == 0) send_gapped(8'($urandom_range(255, 3)));
      send_gapped(8'h02);
      q.delete();
      for (int n = 0; n < FB; n++) q.push_back(8'($urandom_range(255, 0)));
      exp = '0;
      for (int n = 0; n < FB; n++) exp = exp | (MW'(q[n]) << (8 * n));
      foreach (q[n]) send_gapped(q[n]);
      total++; if (measurements_valid !== 1'b1 || measurements !== exp) begin
        bad++; $display("FAIL random_frame[%0d]: got valid=%b meas=%h want 1 %h", f, measurements_valid, measurements, exp);
      end
      repeat ($urandom_range(3, 0)) begin
        tick();
        total++; if (measurements_valid !== 1'b1 || measurements !== exp || input_ready !== 1'b0) begin
          bad++; $display("FAIL random_hold[%0d]: got valid=%b meas=%h ready=%b want 1 %h 0",
                          f, measurements_valid, measurements, input_ready, exp);
        end
      end
      measurements_ready = 1'b1;
      tick();
      measurements_ready = 1'b0;
      total++; if (measurements_valid !== 1'b0) begin bad++; $display("FAIL random_release[%0d]: got %b want 0", f, measurements_valid); end
    end
    total++; if (vrise - v0 != 100) begin bad++; $display("FAIL random_frame_count: got %0d want 100", vrise - v0); end
  endtask

  initial begin
    reset = 1'b1;
    input_valid = 1'b0;
    input_data = 8'h00;
    measurements_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_discard();
    test_payload_no_hdr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
